mercury2_dac_spi: RTL and testbench
===================================

// Module: mercury2_dac_spi
// PURPOSE
//  Parametrised serial driver for the Mercury2 MCP48x2-class SPI DAC (successor to the Busy-only DAC model).
//  Accepts a write request (channel, data), builds a 16-bit command frame and shifts it out on csn/sck/sdi.
//  Reports busy for the whole transfer and mirrors the last value written to each channel.
//  Sits between the analog-output control logic and the DAC pins.
// PARAMETERS
//  DATA_W   10  DAC resolution; 8, 10 or 12. Data is left-justified into frame bits [11:0].
//  CHANNELS 2   DAC channels, 1 or 2. Frame bit15 = channel.
//  CLK_DIV  2   clocks per sck half-period, >=1 (2 -> 12.5 MHz sck from 50 MHz).
//  CSN_GAP  2   clocks csn held high after a frame before the next frame may start, >=1.
//  GAIN_1X  1   frame bit13 (GA): 1 = 1x gain, 0 = 2x gain.
//  LDAC_W   2   ldac low-pulse width in clocks (DAC_SYNC_LDAC_EN only).
// PORTS
//  clk_50MHZ  in   1                  50 MHz onboard oscillator
//  reset_n    in   1                  asynchronous, active-low reset
//  trigger    in   1                  one-clock write request; sampled only when busy=0
//  channel    in   1                  target channel, 0 = A, 1 = B
//  Din        in   DATA_W             sample to write
//  update     in   1                  ldac request (DAC_SYNC_LDAC_EN only)
//  Busy       out  1                  transfer or ldac pulse in progress
//  dropped    out  1                  one-clock pulse: request rejected
//  dac_value  out  CHANNELS*DATA_W    last accepted value per channel; ch0 in LSBs
//  dac_csn, dac_sdi, dac_sck, dac_ldac  out 1  DAC pins
// BEHAVIOUR
//  Reset (async): csn=1, sck=0, sdi=0, Busy=0, dropped=0, dac_value=0, update-pending cleared,
//  ldac=1 with DAC_SYNC_LDAC_EN, else ldac=0. State goes to IDLE. A reset mid-frame aborts it: csn rises immediately.
//  Frame: [15]=channel, [14]=0, [13]=GAIN_1X, [12]=1 (active), [11:0]=Din<<(12-DATA_W). Sent MSB first.
//  SPI mode 0,0: sck idles low. sdi changes only while sck is low. The DAC samples on the sck rising edge.
//  FSM: IDLE -> LOAD -> SHIFT -> HOLD -> GAP -> IDLE (plus LDAC, see CONFIGURATION).
//   IDLE:  Busy=0. If trigger=1 and channel<CHANNELS: latch frame, update dac_value[channel], go to LOAD.
//   LOAD:  1 clk. csn<=0, sdi<=frame[15].
//   SHIFT: 16 bits, each bit sck low CLK_DIV clks then high CLK_DIV clks. On each falling edge the next bit goes on sdi.
//   HOLD:  CLK_DIV clks with sck=0 and csn=0. csn rises at exit, which latches the DAC input register.
//   GAP:   CSN_GAP clks with csn=1. sdi returns to 0.
//  Busy rises the clock after an accepted trigger and stays high for 1+33*CLK_DIV+CSN_GAP clocks (69 at defaults).
//  Busy is registered.
//  Rejection: trigger while Busy=1, or channel>=CHANNELS, gives dropped=1 for one clock.
//   The request is discarded and dac_value is unchanged.
//  Trigger on the same clock Busy falls is accepted (IDLE samples it).
//  Bit counter and divider widths are sized by $clog2; no wrap is visible at the outputs.
// CONFIGURATION
//  `define DAC_SYNC_LDAC_EN: simultaneous update mode.
//   - ldac idles high. Frames only load the DAC input registers.
//   - update=1 in IDLE: state LDAC, ldac=0 for LDAC_W clks, Busy=1, then IDLE.
//   - update during a frame, or with trigger on the same clock: trigger wins and update is held pending.
//     The LDAC pulse runs right after GAP, with no return to IDLE.
//   - Multiple updates during one frame: a single pulse.
//  Macro undefined: dac_ldac tied 0, so each channel updates at csn rise. update is ignored, LDAC state absent.
// TESTING
//  1 trigger, ch0, Din=10'h2A5 -> csn low 67 clks, sdi frame 16'h3A94 on sck rises;
//    Busy 69 clks; dac_value[9:0]=10'h2A5.
//  2 back-to-back: trigger ch1 Din=10'h3FF, second trigger on the clock Busy falls ->
//    second frame 16'hBFFC starts; csn high exactly CSN_GAP=2 clks between frames.
//  3 trigger while Busy=1 (clk 10 of frame) -> dropped 1 clk, no extra frame, dac_value unchanged.
//  4 CHANNELS=1, trigger channel=1 -> dropped=1, csn stays 1, Busy stays 0.
//  5 reset_n low at clk 30 of a frame -> same clock csn=1, sck=0, Busy=0, dac_value=0;
//    next trigger after release gives a full clean frame.
//  6 DAC_SYNC_LDAC_EN: trigger ch0 + update same clk -> frame, GAP, then ldac low 2 clks;
//    Busy total 71 clks; ldac never low during csn low.

Source files
------------

// File: rtl/mercury2_dac_spi.sv
// mercury2_dac_spi: serial write driver for an MCP48x2-class SPI DAC.
// Builds a 16-bit command frame {channel, 0, GA, 1, data<<(12-DATA_W)} from a
// one-clock write request and shifts it out MSB first in SPI mode 0,0.
// Optional macro DAC_SYNC_LDAC_EN: dac_ldac idles high, frames load only the
// input registers, and `update` requests an LDAC low pulse of LDAC_W clocks.
// Without the macro dac_ldac is tied low and `update` is ignored.
//
// Ports:
//   clk_50MHZ, reset_n   clock, asynchronous active-low reset
//   trigger, channel     write request (one clock) and target channel
//   Din                  sample to write
//   update               LDAC request (DAC_SYNC_LDAC_EN only)
//   Busy                 transfer or LDAC pulse in progress (registered)
//   dropped              one-clock pulse when a request is rejected
//   dac_value            last accepted value per channel, ch0 in LSBs
//   dac_csn/sdi/sck/ldac DAC pins
module mercury2_dac_spi #(
  parameter int unsigned DATA_W   = 10,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned CSN_GAP  = 2,
  parameter int unsigned GAIN_1X  = 1,
  parameter int unsigned LDAC_W   = 2
) (
  input  logic                       clk_50MHZ,
  input  logic                       reset_n,
  input  logic                       trigger,
  input  logic                       channel,
  input  logic [DATA_W-1:0]          Din,
  input  logic                       update,
  output logic                       Busy,
  output logic                       dropped,
  output logic [CHANNELS*DATA_W-1:0] dac_value,
  output logic                       dac_csn,
  output logic                       dac_sdi,
  output logic                       dac_sck,
  output logic                       dac_ldac
);

  localparam int unsigned M1      = (CLK_DIV > CSN_GAP) ? CLK_DIV : CSN_GAP;
  localparam int unsigned MAX_CNT = (M1 > LDAC_W) ? M1 : LDAC_W;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(CSN_GAP - 1);
  localparam logic [CNT_W-1:0] LDAC_LAST = CNT_W'(LDAC_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
`ifdef DAC_SYNC_LDAC_EN
    , ST_LDAC
`endif
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       bit_cnt;
  logic [14:0]      shreg;

  logic        chan_ok;
  logic        gap_last;
  logic        go_ldac;
  logic        can_take;
  logic        accept;
  logic [11:0] data12;
  logic [15:0] new_frame;

`ifdef DAC_SYNC_LDAC_EN
  logic ldac_pend;
`endif

  // The last GAP clock doubles as an IDLE sampling point so a trigger on the
  // clock Busy would fall starts the next frame with csn high exactly CSN_GAP.
  always_comb begin
    chan_ok   = (32'(channel) < CHANNELS);
    data12    = 12'(Din) << (12 - DATA_W);
    new_frame = {channel, 1'b0, (GAIN_1X != 0), 1'b1, data12};
    gap_last  = (state == ST_GAP) && (cnt == GAP_LAST);
`ifdef DAC_SYNC_LDAC_EN
    go_ldac   = gap_last && (ldac_pend || update);
`else
    go_ldac   = 1'b0;
`endif
    can_take  = (state == ST_IDLE) || (gap_last && !go_ldac);
    accept    = trigger && chan_ok && can_take;
  end

  always_ff @(posedge clk_50MHZ or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      Busy      <= 1'b0;
      dropped   <= 1'b0;
      dac_value <= '0;
      dac_csn   <= 1'b1;
      dac_sdi   <= 1'b0;
      dac_sck   <= 1'b0;
`ifdef DAC_SYNC_LDAC_EN
      dac_ldac  <= 1'b1;
      ldac_pend <= 1'b0;
`endif
    end else begin
      dropped <= trigger && !accept;
`ifdef DAC_SYNC_LDAC_EN
      if (update && (state != ST_IDLE) && (state != ST_LDAC))
        ldac_pend <= 1'b1;
`endif
      if (accept) begin
        state   <= ST_LOAD;
        Busy    <= 1'b1;
        dac_csn <= 1'b0;
        dac_sdi <= new_frame[15];
        dac_sck <= 1'b0;
        shreg   <= new_frame[14:0];
        cnt     <= '0;
        bit_cnt <= '0;
        for (int unsigned c = 0; c < CHANNELS; c++)
          if (32'(channel) == c)
            dac_value[c*DATA_W +: DATA_W] <= Din;
`ifdef DAC_SYNC_LDAC_EN
        if (update)
          ldac_pend <= 1'b1;
`endif
      end else begin
        case (state)
          ST_IDLE: begin
`ifdef DAC_SYNC_LDAC_EN
            if (update) begin
              state    <= ST_LDAC;
              Busy     <= 1'b1;
              dac_ldac <= 1'b0;
              cnt      <= '0;
            end
`endif
          end
          ST_LOAD: begin
            state <= ST_SHIFT;
            cnt   <= '0;
          end
          ST_SHIFT: begin
            if (cnt == DIV_LAST) begin
              cnt <= '0;
              if (!dac_sck) begin
                dac_sck <= 1'b1;
              end else begin
                dac_sck <= 1'b0;
                if (bit_cnt == 4'd15) begin
                  state <= ST_HOLD;
                end else begin
                  bit_cnt <= bit_cnt + 4'd1;
                  dac_sdi <= shreg[14];
                  shreg   <= {shreg[13:0], 1'b0};
                end
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_HOLD: begin
            if (cnt == DIV_LAST) begin
              dac_csn <= 1'b1;
              dac_sdi <= 1'b0;
              state   <= ST_GAP;
              cnt     <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_GAP: begin
            if (cnt == GAP_LAST) begin
              cnt <= '0;
`ifdef DAC_SYNC_LDAC_EN
              if (go_ldac) begin
                state     <= ST_LDAC;
                dac_ldac  <= 1'b0;
                ldac_pend <= 1'b0;
              end else begin
                state <= ST_IDLE;
                Busy  <= 1'b0;
              end
`else
              state <= ST_IDLE;
              Busy  <= 1'b0;
`endif
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
`ifdef DAC_SYNC_LDAC_EN
          ST_LDAC: begin
            if (cnt == LDAC_LAST) begin
              dac_ldac <= 1'b1;
              Busy     <= 1'b0;
              state    <= ST_IDLE;
              cnt      <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
`endif
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifndef DAC_SYNC_LDAC_EN
  logic unused_update;
  assign unused_update = update;
  assign dac_ldac      = 1'b0;
`endif

endmodule

// File: tb/tb_mercury2_dac_spi.sv
// Self-checking bench for mercury2_dac_spi (default parameters plus a
// single-channel instance). Build with DAC_SYNC_LDAC_EN to also cover LDAC.
module tb_mercury2_dac_spi;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        reset_n, trigger, channel, update;
  logic [9:0]  din;
  logic        busy, dropped, csn, sdi, sck, ldac;
  logic [19:0] dac_value;

  logic        trig1, ch1;
  logic [9:0]  din1;
  logic        busy1, dropped1, csn1, sdi1, sck1, ldac1;
  logic [9:0]  val1;

`ifdef DAC_SYNC_LDAC_EN
  localparam logic LDAC_IDLE = 1'b1;
`else
  localparam logic LDAC_IDLE = 1'b0;
`endif

  mercury2_dac_spi dut (
    .clk_50MHZ(clk), .reset_n(reset_n), .trigger(trigger), .channel(channel),
    .Din(din), .update(update), .Busy(busy), .dropped(dropped),
    .dac_value(dac_value), .dac_csn(csn), .dac_sdi(sdi), .dac_sck(sck),
    .dac_ldac(ldac)
  );

  mercury2_dac_spi #(.CHANNELS(1)) dut1 (
    .clk_50MHZ(clk), .reset_n(reset_n), .trigger(trig1), .channel(ch1),
    .Din(din1), .update(1'b0), .Busy(busy1), .dropped(dropped1),
    .dac_value(val1), .dac_csn(csn1), .dac_sdi(sdi1), .dac_sck(sck1),
    .dac_ldac(ldac1)
  );

  int pass_cnt = 0;
  int total    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Issues a trigger (optionally with update) and watches until Busy drops.
  // A second request is driven during busy cycle t2_at (0 = none).
  task automatic run(input logic c, input logic [9:0] d, input logic upd,
                     input int t2_at, input logic c2, input logic [9:0] d2,
                     output logic [31:0] bits, output int nbits, output int busy_n,
                     output int csn_n, output int gap_n, output int drops,
                     output int ldac_n, output int overlap, output logic timed_out);
    logic prev_sck;
    bits = '0; nbits = 0; busy_n = 0; csn_n = 0; gap_n = 0; drops = 0;
    ldac_n = 0; overlap = 0; timed_out = 1'b1; prev_sck = 1'b0;
    trigger = 1'b1; channel = c; din = d; update = upd;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (!csn) csn_n++;
      if (csn && busy) gap_n++;
      if (dropped) drops++;
      if (!ldac) ldac_n++;
      if (!ldac && !csn) overlap++;
      if (sck && !prev_sck) begin
        bits = {bits[30:0], sdi};
        nbits++;
      end
      prev_sck = sck;
      update = 1'b0;
      if (busy && busy_n == t2_at) begin
        trigger = 1'b1; channel = c2; din = d2;
      end else begin
        trigger = 1'b0;
      end
      if (!busy && busy_n > 0) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  typedef struct {
    logic        c;
    logic [9:0]  d;
    logic [15:0] frame;
    logic [19:0] value;
  } vec_t;

  vec_t vecs[5];

  logic [31:0] bits;
  int nbits, busy_n, csn_n, gap_n, drops, ldac_n, overlap;
  logic to;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 10'h2A5, 16'h3A94, 20'h002A5};
    vecs[1] = '{1'b1, 10'h3FF, 16'hBFFC, 20'hFFEA5};
    vecs[2] = '{1'b0, 10'h000, 16'h3000, 20'hFFC00};
    vecs[3] = '{1'b1, 10'h155, 16'hB554, 20'h55400};
    vecs[4] = '{1'b0, 10'h3FF, 16'h3FFC, 20'h557FF};

    reset_n = 1'b0; trigger = 1'b0; channel = 1'b0; din = '0; update = 1'b0;
    trig1 = 1'b0; ch1 = 1'b0; din1 = '0;
    repeat (2) @(negedge clk);
    check("rst_csn", 32'(csn), 32'd1);
    check("rst_sck", 32'(sck), 32'd0);
    check("rst_sdi", 32'(sdi), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dropped", 32'(dropped), 32'd0);
    check("rst_value", 32'(dac_value), 32'd0);
    check("rst_ldac", 32'(ldac), 32'(LDAC_IDLE));
    check("rst_ldac1", 32'(ldac1), 32'(LDAC_IDLE));
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run(vecs[i].c, vecs[i].d, 1'b0, 0, 1'b0, 10'h0,
          bits, nbits, busy_n, csn_n, gap_n, drops, ldac_n, overlap, to);
      check($sformatf("v%0d_timeout", i), 32'(to), 32'd0);
      check($sformatf("v%0d_nbits", i), 32'(nbits), 32'd16);
      check($sformatf("v%0d_frame", i), 32'(bits[15:0]), 32'(vecs[i].frame));
      check($sformatf("v%0d_busy", i), 32'(busy_n), 32'd69);
      check($sformatf("v%0d_csn_low", i), 32'(csn_n), 32'd67);
      check($sformatf("v%0d_csn_gap", i), 32'(gap_n), 32'd2);
      check($sformatf("v%0d_drops", i), 32'(drops), 32'd0);
      check($sformatf("v%0d_value", i), 32'(dac_value), 32'(vecs[i].value));
`ifdef DAC_SYNC_LDAC_EN
      check($sformatf("v%0d_ldac_idle", i), 32'(ldac_n), 32'd0);
`endif
    end

    // Back-to-back: second trigger on the last Busy clock of the first frame.
    run(1'b1, 10'h3FF, 1'b0, 69, 1'b1, 10'h3FF,
        bits, nbits, busy_n, csn_n, gap_n, drops, ldac_n, overlap, to);
    check("b2b_timeout", 32'(to), 32'd0);
    check("b2b_nbits", 32'(nbits), 32'd32);
    check("b2b_frames", bits, 32'hBFFC_BFFC);
    check("b2b_busy", 32'(busy_n), 32'd138);
    check("b2b_csn_low", 32'(csn_n), 32'd134);
    check("b2b_csn_high", 32'(gap_n), 32'd4);
    check("b2b_drops", 32'(drops), 32'd0);
    check("b2b_value", 32'(dac_value), 32'hFFFFF);

    // Trigger at clock 10 of a frame is rejected.
    run(1'b0, 10'h2A5, 1'b0, 10, 1'b1, 10'h111,
        bits, nbits, busy_n, csn_n, gap_n, drops, ldac_n, overlap, to);
    check("rej_timeout", 32'(to), 32'd0);
    check("rej_nbits", 32'(nbits), 32'd16);
    check("rej_frame", 32'(bits[15:0]), 32'h3A94);
    check("rej_busy", 32'(busy_n), 32'd69);
    check("rej_drops", 32'(drops), 32'd1);
    check("rej_value", 32'(dac_value), 32'hFFEA5);

    // Single-channel instance: channel 1 is out of range.
    trig1 = 1'b1; ch1 = 1'b1; din1 = 10'h123;
    @(negedge clk);
    trig1 = 1'b0;
    check("ch1_dropped", 32'(dropped1), 32'd1);
    check("ch1_busy", 32'(busy1), 32'd0);
    check("ch1_csn", 32'(csn1), 32'd1);
    @(negedge clk);
    check("ch1_dropped_end", 32'(dropped1), 32'd0);
    check("ch1_busy_after", 32'(busy1), 32'd0);
    check("ch1_csn_after", 32'(csn1), 32'd1);
    check("ch1_sck", 32'(sck1), 32'd0);
    check("ch1_sdi", 32'(sdi1), 32'd0);
    check("ch1_value", 32'(val1), 32'd0);
    trig1 = 1'b1; ch1 = 1'b0;
    @(negedge clk);
    trig1 = 1'b0;
    check("ch1_ok_busy", 32'(busy1), 32'd1);
    check("ch1_ok_value", 32'(val1), 32'h123);

    // Asynchronous reset at clock 30 of a frame.
    trigger = 1'b1; channel = 1'b1; din = 10'h0AA;
    @(negedge clk);
    trigger = 1'b0;
    repeat (29) @(negedge clk);
    check("mid_csn_low", 32'(csn), 32'd0);
    reset_n = 1'b0;
    #1;
    check("arst_csn", 32'(csn), 32'd1);
    check("arst_sck", 32'(sck), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_value", 32'(dac_value), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run(1'b0, 10'h2A5, 1'b0, 0, 1'b0, 10'h0,
        bits, nbits, busy_n, csn_n, gap_n, drops, ldac_n, overlap, to);
    check("post_timeout", 32'(to), 32'd0);
    check("post_frame", 32'(bits[15:0]), 32'h3A94);
    check("post_nbits", 32'(nbits), 32'd16);
    check("post_busy", 32'(busy_n), 32'd69);
    check("post_csn_low", 32'(csn_n), 32'd67);
    check("post_value", 32'(dac_value), 32'h002A5);

`ifdef DAC_SYNC_LDAC_EN
    // Trigger and update together: frame, gap, then the LDAC pulse.
    run(1'b0, 10'h155, 1'b1, 0, 1'b0, 10'h0,
        bits, nbits, busy_n, csn_n, gap_n, drops, ldac_n, overlap, to);
    check("sync_timeout", 32'(to), 32'd0);
    check("sync_frame", 32'(bits[15:0]), 32'h3554);
    check("sync_busy", 32'(busy_n), 32'd71);
    check("sync_csn_low", 32'(csn_n), 32'd67);
    check("sync_ldac_low", 32'(ldac_n), 32'd2);
    check("sync_overlap", 32'(overlap), 32'd0);
    check("sync_value", 32'(dac_value), 32'h00155);
    // Update alone from IDLE.
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
    check("upd_busy1", 32'(busy), 32'd1);
    check("upd_ldac1", 32'(ldac), 32'd0);
    @(negedge clk);
    check("upd_busy2", 32'(busy), 32'd1);
    check("upd_ldac2", 32'(ldac), 32'd0);
    @(negedge clk);
    check("upd_busy3", 32'(busy), 32'd0);
    check("upd_ldac3", 32'(ldac), 32'd1);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
